// File: rtl/toast_pkg.sv
// Shared types and constants for the toaster phase sequencer, its wrapper and bench decode.
package toast_pkg;

  // Encoding is visible on the ooState port, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WARMUP    = 2'b01,
    TOAST     = 2'b10,
    COOL_DOWN = 2'b11
  } state_t;

  // Config write targets; the fourth code is reserved and writes to it are dropped.
  localparam logic [1:0] CFG_WARM  = 2'b00;
  localparam logic [1:0] CFG_TOAST = 2'b01;
  localparam logic [1:0] CFG_COOL  = 2'b10;
  localparam logic [1:0] CFG_RSVD  = 2'b11;

endpackage

// File: rtl/toast_sequencer_if.sv
// Control, config and status signals of the toast sequencer, bundled for the block boundary.
interface toast_sequencer_if #(
  parameter int unsigned CNT_W = 8
);

  logic             iiStart;
  logic [1:0]       iiLevel;
  logic             iiAbort;
  logic             iiCfgWe;
  logic [1:0]       iiCfgSel;
  logic [CNT_W-1:0] iiCfgData;
  logic [1:0]       ooState;
  logic             ooHeater;
  logic             ooFan;
  logic             ooBusy;
  logic             ooDone;
  logic [CNT_W+1:0] ooRemaining;

  // Sequencer side.
  modport slave (
    input  iiStart, iiLevel, iiAbort, iiCfgWe, iiCfgSel, iiCfgData,
    output ooState, ooHeater, ooFan, ooBusy, ooDone, ooRemaining
  );

  // Controller / bench side.
  modport master (
    output iiStart, iiLevel, iiAbort, iiCfgWe, iiCfgSel, iiCfgData,
    input  ooState, ooHeater, ooFan, ooBusy, ooDone, ooRemaining
  );

endinterface

// File: rtl/phase_timer.sv
// Down-counter for one phase: loads a start count, then decrements to zero and holds there.
module phase_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  // Load wins over decrement; the count parks at zero between phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/toast_sequencer.sv
// Timed IDLE -> WARMUP -> TOAST -> COOL_DOWN controller driving heater and fan enables.
module toast_sequencer
  import toast_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned WARM_DEF  = 4,
  parameter int unsigned TOAST_DEF = 6,
  parameter int unsigned COOL_DEF  = 3
) (
  input  logic            iiClk,
  input  logic            iiRst,
  toast_sequencer_if.slave bus
);

  localparam int unsigned TW = CNT_W + 2;
  typedef logic [TW-1:0] tcnt_t;

  logic [CNT_W-1:0] warm_q, toast_q, cool_q;
  state_t           state_q;
  logic [1:0]       level_q;
  logic             done_q;

  logic             tmr_load;
  tcnt_t            tmr_load_val;
  tcnt_t            tmr_count;
  logic             tmr_zero;
  tcnt_t            toast_len;

  // Timer start value for a phase of d cycles; a zero duration still lasts one cycle.
  function automatic tcnt_t first_count(input tcnt_t d);
    return (d == '0) ? '0 : d - tcnt_t'(1);
  endfunction

  // Toast length scales with darkness; TW bits hold 255*4 without wrapping.
  always_comb begin
    toast_len = tcnt_t'(toast_q) * tcnt_t'({1'b0, level_q} + 3'd1);
  end

  // Config registers; the load logic reads them before the write lands, so a same-edge
  // write to the loading phase only affects later loads.
  always_ff @(posedge iiClk or posedge iiRst) begin
    if (iiRst) begin
      warm_q  <= CNT_W'(WARM_DEF);
      toast_q <= CNT_W'(TOAST_DEF);
      cool_q  <= CNT_W'(COOL_DEF);
    end else if (bus.iiCfgWe) begin
      case (bus.iiCfgSel)
        CFG_WARM:  warm_q  <= bus.iiCfgData;
        CFG_TOAST: toast_q <= bus.iiCfgData;
        CFG_COOL:  cool_q  <= bus.iiCfgData;
        default:   ;
      endcase
    end
  end

  // Timer load on every phase entry, mirroring the FSM transitions below.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      IDLE: begin
        if (bus.iiStart && !bus.iiAbort) begin
          tmr_load     = 1'b1;
          tmr_load_val = first_count(tcnt_t'(warm_q));
        end
      end
      WARMUP: begin
        if (bus.iiAbort) begin
          tmr_load     = 1'b1;
          tmr_load_val = first_count(tcnt_t'(cool_q));
        end else if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = first_count(toast_len);
        end
      end
      TOAST: begin
        if (bus.iiAbort || tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = first_count(tcnt_t'(cool_q));
        end
      end
      default: ;
    endcase
  end

  // Phase FSM with the latched darkness level and the registered done pulse.
  always_ff @(posedge iiClk or posedge iiRst) begin
    if (iiRst) begin
      state_q <= IDLE;
      level_q <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iiStart && !bus.iiAbort) begin
            state_q <= WARMUP;
            level_q <= bus.iiLevel;
          end
        end
        WARMUP: begin
          if (bus.iiAbort) begin
            state_q <= COOL_DOWN;
          end else if (tmr_zero) begin
            state_q <= TOAST;
          end
        end
        TOAST: begin
          if (bus.iiAbort || tmr_zero) begin
            state_q <= COOL_DOWN;
          end
        end
        COOL_DOWN: begin
          if (tmr_zero) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  phase_timer #(
    .W(TW)
  ) u_timer (
    .clk      (iiClk),
    .rst      (iiRst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign bus.ooState     = state_q;
  assign bus.ooHeater    = (state_q == WARMUP) || (state_q == TOAST);
  assign bus.ooFan       = (state_q == COOL_DOWN);
  assign bus.ooBusy      = (state_q != IDLE);
  assign bus.ooDone      = done_q;
  assign bus.ooRemaining = tmr_count;

endmodule

// File: tb/tb_toast_sequencer.sv
// Directed bench for toast_sequencer: a vector table for a default run plus hand sequences.
module tb_toast_sequencer;
  import toast_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  toast_sequencer_if #(.CNT_W(8)) bus ();

  toast_sequencer #(
    .CNT_W     (8),
    .WARM_DEF  (4),
    .TOAST_DEF (6),
    .COOL_DEF  (3)
  ) dut (
    .iiClk (clk),
    .iiRst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic   start;
    logic   abort;
    state_t st;
    int     rem;
    logic   dn;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check; heater/fan/busy expectations come from the state decode.
  task automatic check_out(input string tag, input state_t st, input int rem, input logic dn);
    chk({tag, "_state"}, 32'(bus.ooState), 32'(st));
    chk({tag, "_heater"}, 32'(bus.ooHeater), 32'((st == WARMUP) || (st == TOAST)));
    chk({tag, "_fan"}, 32'(bus.ooFan), 32'(st == COOL_DOWN));
    chk({tag, "_busy"}, 32'(bus.ooBusy), 32'(st != IDLE));
    chk({tag, "_done"}, 32'(bus.ooDone), 32'(dn));
    chk({tag, "_rem"}, 32'(bus.ooRemaining), 32'(rem));
  endtask

  // Count cycles spent in st starting from the current cycle, bounded by limit.
  task automatic count_phase(input state_t st, input int limit, output int n);
    n = 0;
    while (bus.ooState == st && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic start_run(input logic [1:0] level);
    bus.iiStart = 1'b1;
    bus.iiLevel = level;
    tick();
    bus.iiStart = 1'b0;
    bus.iiLevel = 2'd0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    bus.iiCfgWe   = 1'b1;
    bus.iiCfgSel  = sel;
    bus.iiCfgData = data;
    tick();
    bus.iiCfgWe   = 1'b0;
  endtask

  task automatic finish_idle(input string tag);
    chk({tag, "_idle"}, 32'(bus.ooState), 32'(IDLE));
    chk({tag, "_done"}, 32'(bus.ooDone), 32'd1);
    tick();
    chk({tag, "_done_clr"}, 32'(bus.ooDone), 32'd0);
  endtask

  task automatic run_counts(input string tag, input int w, input int t, input int c);
    int n;
    count_phase(WARMUP, 2000, n);
    chk({tag, "_warm"}, 32'(n), 32'(w));
    count_phase(TOAST, 2000, n);
    chk({tag, "_toast"}, 32'(n), 32'(t));
    count_phase(COOL_DOWN, 2000, n);
    chk({tag, "_cool"}, 32'(n), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dcount;

    // Default run, level 0: 4 warm, 6 toast, 3 cool cycles, then a done pulse.
    tbl[0]  = '{1'b1, 1'b0, WARMUP,    3, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, WARMUP,    2, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, WARMUP,    1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, WARMUP,    0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, TOAST,     5, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, TOAST,     4, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, TOAST,     3, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, TOAST,     2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, TOAST,     1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, TOAST,     0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, COOL_DOWN, 2, 1'b0};
    tbl[11] = '{1'b0, 1'b0, COOL_DOWN, 1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, COOL_DOWN, 0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, IDLE,      0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, IDLE,      0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, IDLE,      0, 1'b0};

    bus.iiStart   = 1'b0;
    bus.iiLevel   = 2'd0;
    bus.iiAbort   = 1'b0;
    bus.iiCfgWe   = 1'b0;
    bus.iiCfgSel  = 2'd0;
    bus.iiCfgData = 8'd0;
    rst = 1'b1;
    tick();
    tick();
    check_out("reset", IDLE, 0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      bus.iiStart = tbl[i].start;
      bus.iiAbort = tbl[i].abort;
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].rem, tbl[i].dn);
    end
    bus.iiStart = 1'b0;
    bus.iiAbort = 1'b0;

    // Level 3 quadruples the toast phase.
    start_run(2'd3);
    count_phase(WARMUP, 50, n);
    chk("l3_warm", 32'(n), 32'd4);
    chk("l3_rem_first", 32'(bus.ooRemaining), 32'd23);
    count_phase(TOAST, 100, n);
    chk("l3_toast", 32'(n), 32'd24);
    count_phase(COOL_DOWN, 50, n);
    chk("l3_cool", 32'(n), 32'd3);
    finish_idle("l3");

    // Abort on the second toast cycle; abort during cool-down is ignored.
    start_run(2'd0);
    count_phase(WARMUP, 50, n);
    chk("ab_warm", 32'(n), 32'd4);
    tick();
    chk("ab_toast2", 32'(bus.ooState), 32'(TOAST));
    bus.iiAbort = 1'b1;
    tick();
    check_out("ab_cool1", COOL_DOWN, 2, 1'b0);
    count_phase(COOL_DOWN, 50, n);
    chk("ab_cool", 32'(n), 32'd3);
    bus.iiAbort = 1'b0;
    chk("ab_done", 32'(bus.ooDone), 32'd1);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ooDone) dcount++;
    end
    chk("ab_done_once", 32'(dcount), 32'd0);

    // warm=0 lasts one cycle; cool write during toast applies to this run's cool-down.
    cfg_write(CFG_WARM, 8'd0);
    start_run(2'd0);
    count_phase(WARMUP, 50, n);
    chk("cw_warm0", 32'(n), 32'd1);
    cfg_write(CFG_COOL, 8'd5);
    count_phase(TOAST, 50, n);
    chk("cw_toast_rest", 32'(n), 32'd5);
    count_phase(COOL_DOWN, 50, n);
    chk("cw_cool_now", 32'(n), 32'd5);
    finish_idle("cw");

    // Cool write during cool-down affects only the next run.
    start_run(2'd0);
    count_phase(WARMUP, 50, n);
    chk("cc_warm", 32'(n), 32'd1);
    count_phase(TOAST, 50, n);
    chk("cc_toast", 32'(n), 32'd6);
    cfg_write(CFG_COOL, 8'd2);
    count_phase(COOL_DOWN, 50, n);
    chk("cc_cool_rest", 32'(n), 32'd4);
    finish_idle("cc");

    // Maximum toast length, no wrap.
    cfg_write(CFG_TOAST, 8'd255);
    start_run(2'd3);
    count_phase(WARMUP, 50, n);
    chk("mx_warm", 32'(n), 32'd1);
    chk("mx_rem_first", 32'(bus.ooRemaining), 32'd1019);
    count_phase(TOAST, 1100, n);
    chk("mx_toast", 32'(n), 32'd1020);
    count_phase(COOL_DOWN, 50, n);
    chk("mx_cool", 32'(n), 32'd2);
    finish_idle("mx");

    // Reserved write dropped; warm write in the start cycle uses the old value.
    cfg_write(CFG_RSVD, 8'd9);
    bus.iiCfgWe   = 1'b1;
    bus.iiCfgSel  = CFG_WARM;
    bus.iiCfgData = 8'd7;
    bus.iiStart   = 1'b1;
    tick();
    bus.iiCfgWe   = 1'b0;
    bus.iiStart   = 1'b0;
    run_counts("rs", 1, 255, 2);
    finish_idle("rs");

    // Asynchronous reset mid-warm-up restores defaults.
    start_run(2'd0);
    tick();
    chk("rs_mid_warm", 32'(bus.ooState), 32'(WARMUP));
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", IDLE, 0, 1'b0);
    rst = 1'b0;
    start_run(2'd0);
    run_counts("dflt", 4, 6, 3);
    finish_idle("dflt");

    // Start during toast is ignored.
    start_run(2'd0);
    count_phase(WARMUP, 50, n);
    chk("sb_warm", 32'(n), 32'd4);
    bus.iiStart = 1'b1;
    tick();
    bus.iiStart = 1'b0;
    count_phase(TOAST, 50, n);
    chk("sb_toast_rest", 32'(n), 32'd5);
    count_phase(COOL_DOWN, 50, n);
    chk("sb_cool", 32'(n), 32'd3);
    finish_idle("sb");

    // Start with abort stays idle; held start restarts right after done.
    bus.iiStart = 1'b1;
    bus.iiAbort = 1'b1;
    tick();
    chk("sa_idle", 32'(bus.ooState), 32'(IDLE));
    bus.iiAbort = 1'b0;
    tick();
    chk("hold_warm", 32'(bus.ooState), 32'(WARMUP));
    run_counts("hold", 4, 6, 3);
    chk("hold_done", 32'(bus.ooDone), 32'd1);
    chk("hold_idle", 32'(bus.ooState), 32'(IDLE));
    tick();
    check_out("hold_restart", WARMUP, 3, 1'b0);
    bus.iiStart = 1'b0;
    bus.iiAbort = 1'b1;
    tick();
    bus.iiAbort = 1'b0;
    chk("hold_abort_warm", 32'(bus.ooState), 32'(COOL_DOWN));
    count_phase(COOL_DOWN, 50, n);
    chk("hold_cool", 32'(n), 32'd3);
    finish_idle("hold_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
